// File: rtl/rv32i_types.sv
// Shared types for the RV32I pipeline control: controller states, PC redirect
// select encoding and the load-use hazard predicate.
package rv32i_types;

    typedef enum logic {
        RUN      = 1'b0,
        WAIT_MEM = 1'b1
    } ctrl_state_t;

    typedef enum logic [1:0] {
        REDIR_NONE = 2'd0,
        REDIR_JAL  = 2'd1,
        REDIR_EX   = 2'd2
    } redir_sel_t;

    localparam int unsigned CNT_W = 32;

    // x0 never carries a loaded value, so a load to x0 cannot create a hazard.
    function automatic logic load_use_hazard(
        input logic       mem_read,
        input logic [4:0] rd,
        input logic [4:0] rs1,
        input logic [4:0] rs2
    );
        return mem_read && (rd != 5'd0) && ((rd == rs1) || (rd == rs2));
    endfunction

endpackage

// File: rtl/pipeline_ctrl_sat_counter.sv
// Saturating up-counter with asynchronous active-low clear and a synchronous
// preload; holds at all-ones instead of wrapping.
module sat_counter
    import rv32i_types::*;
#(
    parameter int unsigned W = CNT_W
) (
    input  logic         clk,
    input  logic         clr_n,
    input  logic         en,
    input  logic         load,
    input  logic [W-1:0] load_value,
    output logic [W-1:0] count
);

    logic [W-1:0] count_reg;

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= load_value;
        end else if (en && (count_reg != {W{1'b1}})) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign count = count_reg;

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline hazard/stall controller: freezes on outstanding cache accesses,
// inserts load-use bubbles, and flushes on JAL / EX redirects.
module pipeline_ctrl
    import rv32i_types::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        icache_req,
    input  logic        icache_resp,
    input  logic        dcache_req,
    input  logic        dcache_resp,
    input  logic        direct_jump,
    input  logic        br_mispredict,
    input  logic        id_ex_mem_read,
    input  logic [4:0]  id_ex_rd,
    input  logic [4:0]  if_id_rs1,
    input  logic [4:0]  if_id_rs2,
    output logic        load_pc,
    output logic        load_if_id,
    output logic        load_id_ex,
    output logic        load_ex_mem,
    output logic        load_mem_wb,
    output logic        flush_if_id,
    output logic        flush_id_ex,
    output logic [1:0]  redirect_sel,
    output logic        icache_hold,
    output logic        dcache_hold,
    output logic [31:0] stall_count,
    output logic [31:0] flush_count
);

    ctrl_state_t state_reg, state_next;
    logic        i_done_reg, i_done_next;
    logic        d_done_reg, d_done_next;
    logic        mem_stall;
    logic        load_use;
    logic        bubble;
    logic [4:0]  load_vec;
    logic        flush_if_id_next, flush_id_ex_next;
    redir_sel_t  redir;

    // A completed response only counts as "done" until the pipeline moves on.
    assign mem_stall = (icache_req & ~(icache_resp | i_done_reg))
                     | (dcache_req & ~(dcache_resp | d_done_reg));
    assign load_use  = load_use_hazard(id_ex_mem_read, id_ex_rd, if_id_rs1, if_id_rs2);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg  <= RUN;
            i_done_reg <= 1'b0;
            d_done_reg <= 1'b0;
        end else begin
            state_reg  <= state_next;
            i_done_reg <= i_done_next;
            d_done_reg <= d_done_next;
        end
    end

    always_comb begin
        state_next       = state_reg;
        i_done_next      = 1'b0;
        d_done_next      = 1'b0;
        load_vec         = 5'b00000;
        flush_if_id_next = 1'b0;
        flush_id_ex_next = 1'b0;
        redir            = REDIR_NONE;
        bubble           = 1'b0;

        case (state_reg)
            RUN:      if (mem_stall)  state_next = WAIT_MEM;
            WAIT_MEM: if (!mem_stall) state_next = RUN;
            default:  state_next = RUN;
        endcase

        if (mem_stall) begin
            i_done_next = i_done_reg | icache_resp;
            d_done_next = d_done_reg | dcache_resp;
        end

        // Priority: reset, memory freeze, EX redirect, load-use, JAL.
        if (!rst || mem_stall) begin
            load_vec = 5'b00000;
        end else if (br_mispredict) begin
            load_vec         = 5'b11111;
            flush_if_id_next = 1'b1;
            flush_id_ex_next = 1'b1;
            redir            = REDIR_EX;
        end else if (load_use) begin
            load_vec         = 5'b00111;
            flush_id_ex_next = 1'b1;
            bubble           = 1'b1;
        end else if (direct_jump) begin
            load_vec         = 5'b11111;
            flush_if_id_next = 1'b1;
            redir            = REDIR_JAL;
        end else begin
            load_vec = 5'b11111;
        end
    end

    assign {load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb} = load_vec;
    assign flush_if_id  = flush_if_id_next;
    assign flush_id_ex  = flush_id_ex_next;
    assign redirect_sel = redir;
    assign icache_hold  = i_done_reg;
    assign dcache_hold  = d_done_reg;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk        (clk),
        .clr_n      (rst),
        .en         (mem_stall | bubble),
        .load       (1'b0),
        .load_value ('0),
        .count      (stall_count)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk        (clk),
        .clr_n      (rst),
        .en         (flush_if_id_next),
        .load       (1'b0),
        .load_value ('0),
        .count      (flush_count)
    );

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: a rule-level model checked every
// cycle, plus directed scenarios with hand-computed literal expectations.
module tb_pipeline_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic icache_req = 0, icache_resp = 0, dcache_req = 0, dcache_resp = 0;
    logic direct_jump = 0, br_mispredict = 0, id_ex_mem_read = 0;
    logic [4:0] id_ex_rd = 0, if_id_rs1 = 0, if_id_rs2 = 0;

    logic load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb;
    logic flush_if_id, flush_id_ex, icache_hold, dcache_hold;
    logic [1:0]  redirect_sel;
    logic [31:0] stall_count, flush_count;

    logic        sat_load = 0, sat_en = 0;
    logic [31:0] sat_value = 0, sat_count;

    int checks = 0;
    int failures = 0;
    bit run_checks = 1'b1;

    always #5 clk = ~clk;

    pipeline_ctrl dut (
        .clk(clk), .rst(rst),
        .icache_req(icache_req), .icache_resp(icache_resp),
        .dcache_req(dcache_req), .dcache_resp(dcache_resp),
        .direct_jump(direct_jump), .br_mispredict(br_mispredict),
        .id_ex_mem_read(id_ex_mem_read), .id_ex_rd(id_ex_rd),
        .if_id_rs1(if_id_rs1), .if_id_rs2(if_id_rs2),
        .load_pc(load_pc), .load_if_id(load_if_id), .load_id_ex(load_id_ex),
        .load_ex_mem(load_ex_mem), .load_mem_wb(load_mem_wb),
        .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex),
        .redirect_sel(redirect_sel),
        .icache_hold(icache_hold), .dcache_hold(dcache_hold),
        .stall_count(stall_count), .flush_count(flush_count)
    );

    sat_counter #(.W(32)) u_sat (
        .clk(clk), .clr_n(rst), .en(sat_en), .load(sat_load),
        .load_value(sat_value), .count(sat_count)
    );

    wire [4:0] act_loads = {load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb};
    wire [1:0] act_flush = {flush_if_id, flush_id_ex};

    typedef struct packed {
        logic [4:0] loads;
        logic [1:0] flushes;   // {if_id, id_ex}
        logic [1:0] redir;
        logic       stalled;
        logic       bubble;
    } exp_t;

    // Expected outputs straight from the priority rules.
    function automatic exp_t model_eval(
        input logic rst_v, ireq, iresp, dreq, dresp, idone, ddone,
        input logic jal, br, mr, input logic [4:0] rd, rs1, rs2
    );
        exp_t e;
        logic lu;
        e  = '0;
        lu = mr && (rd != 0) && (rd == rs1 || rd == rs2);
        if (!rst_v) return e;
        e.stalled = (ireq && !iresp && !idone) || (dreq && !dresp && !ddone);
        if (e.stalled) begin
            e.loads = 5'b00000;
        end else if (br) begin
            e.loads = 5'b11111; e.flushes = 2'b11; e.redir = 2'd2;
        end else if (lu) begin
            e.loads = 5'b00111; e.flushes = 2'b01; e.bubble = 1'b1;
        end else if (jal) begin
            e.loads = 5'b11111; e.flushes = 2'b10; e.redir = 2'd1;
        end else begin
            e.loads = 5'b11111;
        end
        return e;
    endfunction

    logic    m_idone = 0, m_ddone = 0;
    longint  m_stall = 0, m_flush = 0;
    exp_t    cur_exp;

    assign cur_exp = model_eval(rst, icache_req, icache_resp, dcache_req, dcache_resp,
                                m_idone, m_ddone, direct_jump, br_mispredict,
                                id_ex_mem_read, id_ex_rd, if_id_rs1, if_id_rs2);

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_idone <= 1'b0;
            m_ddone <= 1'b0;
            m_stall <= 0;
            m_flush <= 0;
        end else begin
            m_idone <= cur_exp.stalled ? (m_idone | icache_resp) : 1'b0;
            m_ddone <= cur_exp.stalled ? (m_ddone | dcache_resp) : 1'b0;
            if ((cur_exp.stalled || cur_exp.bubble) && m_stall < 64'hFFFF_FFFF)
                m_stall <= m_stall + 1;
            if (cur_exp.flushes[1] && m_flush < 64'hFFFF_FFFF)
                m_flush <= m_flush + 1;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s t=%0t actual=%0h required=%0h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (run_checks) begin
            check("model_loads", 64'(act_loads), 64'(cur_exp.loads));
            check("model_flush", 64'(act_flush), 64'(cur_exp.flushes));
            check("model_redir", 64'(redirect_sel), 64'(cur_exp.redir));
            check("model_holds", 64'({icache_hold, dcache_hold}), 64'({m_idone, m_ddone}));
            check("model_stall_count", 64'(stall_count), 64'(m_stall));
            check("model_flush_count", 64'(flush_count), 64'(m_flush));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        icache_req = 0; icache_resp = 0; dcache_req = 0; dcache_resp = 0;
        direct_jump = 0; br_mispredict = 0; id_ex_mem_read = 0;
        id_ex_rd = 0; if_id_rs1 = 0; if_id_rs2 = 0;
    endtask

    initial begin
        #2 rst = 1'b0;
        step(); step();
        @(negedge clk);
        check("rst_loads", 64'(act_loads), 64'h0);
        check("rst_counts", 64'({stall_count, flush_count}), 64'h0);
        step();
        rst = 1'b1;
        @(negedge clk); check("idle_loads", 64'(act_loads), 64'h1f);
        step();

        // icache miss answered on the fourth cycle
        icache_req = 1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk); check("imiss_loads", 64'(act_loads), 64'h0);
            step();
        end
        icache_resp = 1;
        @(negedge clk);
        check("imiss_done_loads", 64'(act_loads), 64'h1f);
        check("imiss_stall_count", 64'(stall_count), 64'd3);
        step(); clear_inputs();

        // both caches: icache answers cycle 2, dcache cycle 5
        icache_req = 1; dcache_req = 1;
        step(); icache_resp = 1;
        step(); icache_resp = 0;
        @(negedge clk); check("ihold_c3", 64'(icache_hold), 64'h1);
        step();
        @(negedge clk); check("ihold_c4", 64'(icache_hold), 64'h1);
        step(); dcache_resp = 1;
        @(negedge clk);
        check("ihold_c5", 64'(icache_hold), 64'h1);
        check("advance_c5", 64'(act_loads), 64'h1f);
        check("both_stall_count", 64'(stall_count), 64'd7);
        step(); clear_inputs();
        @(negedge clk); check("ihold_c6", 64'(icache_hold), 64'h0);
        step();

        // simultaneous responses
        icache_req = 1; dcache_req = 1;
        step(); icache_resp = 1; dcache_resp = 1;
        @(negedge clk); check("same_cycle_advance", 64'(act_loads), 64'h1f);
        step(); clear_inputs();

        // load-use on rs2, then rs1 with a JAL pending, then rd=x0
        id_ex_mem_read = 1; id_ex_rd = 5; if_id_rs2 = 5;
        @(negedge clk);
        check("lu_rs2_loads", 64'(act_loads), 64'h07);
        check("lu_rs2_flush", 64'(act_flush), 64'h1);
        step(); if_id_rs2 = 0; if_id_rs1 = 5; direct_jump = 1;
        @(negedge clk);
        check("lu_jal_redir", 64'(redirect_sel), 64'h0);
        check("lu_jal_flush", 64'(act_flush), 64'h1);
        step(); id_ex_rd = 0; if_id_rs1 = 0; direct_jump = 0;
        @(negedge clk); check("lu_x0_loads", 64'(act_loads), 64'h1f);
        step(); id_ex_rd = 5; if_id_rs1 = 6; if_id_rs2 = 7;
        @(negedge clk); check("lu_nomatch_loads", 64'(act_loads), 64'h1f);
        step(); clear_inputs();

        // mispredict overrides JAL and load-use
        id_ex_mem_read = 1; id_ex_rd = 5; if_id_rs1 = 5; direct_jump = 1; br_mispredict = 1;
        @(negedge clk);
        check("br_redir", 64'(redirect_sel), 64'h2);
        check("br_flush", 64'(act_flush), 64'h3);
        check("br_loads", 64'(act_loads), 64'h1f);
        check("br_flush_count_before", 64'(flush_count), 64'd0);
        step(); clear_inputs();
        @(negedge clk); check("br_flush_count_after", 64'(flush_count), 64'd1);
        step();

        // JAL alone
        direct_jump = 1;
        @(negedge clk);
        check("jal_redir", 64'(redirect_sel), 64'h1);
        check("jal_flush", 64'(act_flush), 64'h2);
        step(); clear_inputs();

        // memory freeze masks a mispredict
        dcache_req = 1; br_mispredict = 1;
        @(negedge clk);
        check("stall_br_redir", 64'(redirect_sel), 64'h0);
        check("stall_br_flush", 64'(act_flush), 64'h0);
        step(); dcache_resp = 1;
        @(negedge clk); check("stall_br_release", 64'(redirect_sel), 64'h2);
        step(); clear_inputs();

        // reset during WAIT_MEM with a captured dcache response
        icache_req = 1; dcache_req = 1;
        step(); dcache_resp = 1;
        step(); dcache_resp = 0;
        #1 check("pre_rst_dhold", 64'(dcache_hold), 64'h1);
        #1 rst = 1'b0;
        #1;
        check("midrst_loads", 64'(act_loads), 64'h0);
        check("midrst_dhold", 64'(dcache_hold), 64'h0);
        check("midrst_counts", 64'({stall_count, flush_count}), 64'h0);
        step(); clear_inputs();
        step(); rst = 1'b1;
        @(negedge clk);
        check("postrst_loads", 64'(act_loads), 64'h1f);
        check("postrst_holds", 64'({icache_hold, dcache_hold}), 64'h0);
        check("postrst_stall_count", 64'(stall_count), 64'd0);
        step();

        // saturation from a preloaded value
        sat_value = 32'hFFFF_FFFE; sat_load = 1;
        step(); sat_load = 0; sat_en = 1;
        @(negedge clk); check("sat_preload", 64'(sat_count), 64'hFFFF_FFFE);
        for (int c = 0; c < 3; c++) begin
            step();
            @(negedge clk); check("sat_hold", 64'(sat_count), 64'hFFFF_FFFF);
        end
        step(); sat_en = 0;

        run_checks = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
